mult_div_unit: RTL and testbench

Multiply/divide unit for the P7 pipeline. It is the responder to the `MAD_start` / `MAD_sel` / `HI_En` / `LO_En` control carried down the pipeline, and it generates the `Busy` indication that the hazard unit consumes. It accepts one operation per request, models multi-cycle latency with a down-counter, and commits results to architectural HI/LO registers. It sits beside the ALU in the E stage.

---
 rtl/md_pkg.sv | 18 +
 rtl/mult_div_unit.sv | 140 ++++++++++++++
 tb/tb_mult_div_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MADDU = 3'd7
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers and a busy down-counter.
// Optional madd/maddu support is enabled by defining MULT_DIV_MADD_EN.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, safe_b, q_mag, r_mag;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        accept_c;

    // Datapath: products and sign-magnitude division (avoids INT_MIN / -1 overflow)
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        mag_a  = A[31] ? (32'd0 - A) : A;
        mag_b  = B[31] ? (32'd0 - B) : B;
        safe_b = (B == 32'd0) ? 32'd1 : mag_b;
        q_mag  = mag_a / safe_b;
        r_mag  = mag_a % safe_b;
        quot_s = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
        rem_s  = A[31] ? (32'd0 - r_mag) : r_mag;
        quot_u = A / ((B == 32'd0) ? 32'd1 : B);
        rem_u  = A % ((B == 32'd0) ? 32'd1 : B);
    end

    assign accept_c = start && !cancel && !busy_q;

    // Next-state: request decode in IDLE, countdown and commit in RUN
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    case (md_op)
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        MD_MULT, MD_MULTU: begin
                            pend_d    = (md_op == MD_MULT) ? prod_s : prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_d    = (md_op == MD_DIV) ? {rem_s, quot_s} : {rem_u, quot_u};
                            pend_wr_d = (B != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
`ifdef MULT_DIV_MADD_EN
                        MD_MADD, MD_MADDU: begin
                            pend_d    = {hi_q, lo_q} + ((md_op == MD_MADD) ? prod_s : prod_u);
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results, move/accumulate, cancel, reset abort.
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, cancel;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .cancel (cancel),
        .A      (a),
        .B      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle request, then count cycles with busy high (bounded)
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, output int cycles);
        @(negedge clk);
        start = 1'b1; md_op = op; a = av; b = bv; cancel = cv;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; md_op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check_regs("reset", 32'h0, 32'h0);

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, cyc);
        check("mult lat", 64'(cyc), 64'd5);
        check_regs("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, cyc);
        check("multu lat", 64'(cyc), 64'd5);
        check_regs("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
        check("div lat", 64'(cyc), 64'd10);
        check_regs("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(MD_DIVU, 32'd7, 32'd0, 1'b0, cyc);
        check("divu0 lat", 64'(cyc), 64'd10);
        check_regs("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, cyc);
        check("mthi busy", 64'(cyc), 64'd0);
        check_regs("mthi", 32'h1234_5678, 32'hFFFF_FFFD);

        run_op(MD_MTLO, 32'h9, 32'd0, 1'b0, cyc);
        check("mtlo busy", 64'(cyc), 64'd0);
        check_regs("mtlo", 32'h1234_5678, 32'h9);

        run_op(MD_MADD, 32'd2, 32'd3, 1'b0, cyc);
`ifdef MULT_DIV_MADD_EN
        check("madd lat", 64'(cyc), 64'd5);
        check_regs("madd", 32'h1234_5678, 32'hF);
`else
        check("madd off busy", 64'(cyc), 64'd0);
        check_regs("madd off", 32'h1234_5678, 32'h9);
`endif

        run_op(MD_MULT, 32'd100, 32'd100, 1'b1, cyc);
        check("cancel busy", 64'(cyc), 64'd0);
`ifdef MULT_DIV_MADD_EN
        check_regs("cancel", 32'h1234_5678, 32'hF);
`else
        check_regs("cancel", 32'h1234_5678, 32'h9);
`endif

        // Requests held while busy must be ignored; original commits on time
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        check("ignore busy", 64'(busy), 64'd1);
        md_op = MD_MTHI; a = 32'hDEAD_BEEF;
        @(negedge clk);
        md_op = MD_DIV; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("ignore lat", 64'(cyc), 64'd5);
        check_regs("ignore", 32'h0, 32'hC);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
        check_regs("div ovf", 32'h0, 32'h8000_0000);

        run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, cyc);
        check_regs("divu", 32'h2, 32'hE);

        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, cyc);
        check_regs("div negdiv", 32'h1, 32'hFFFF_FFFD);

        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, cyc);
        check_regs("mult min", 32'h4000_0000, 32'h0);

        // Reset in the third busy cycle aborts the divide without a late commit
        @(negedge clk);
        start = 1'b1; md_op = MD_DIV; a = 32'd20; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check_regs("abort", 32'h0, 32'h0);
        repeat (12) @(negedge clk);
        check("abort late busy", 64'(busy), 64'd0);
        check_regs("abort late", 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
